// File: rtl/uart_tx_frame_if.sv
// ---------------------------------------------------------------------------
// uart_tx_frame_if
// Payload handshake between the UART FIFO / bus bridge and the transmit
// engine. A transfer happens on a rising clk edge where din_valid and
// din_ready are both high.
//
//   din        payload, LSB is sent first on the line
//   din_valid  producer has a payload ready
//   din_ready  transmit engine can take the payload this cycle
//
// master : payload producer (FIFO / bridge / testbench)
// slave  : uart_tx_frame
// ---------------------------------------------------------------------------
interface uart_tx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] din;
  logic                 din_valid;
  logic                 din_ready;

  modport master (
    output din,
    output din_valid,
    input  din_ready
  );

  modport slave (
    input  din,
    input  din_valid,
    output din_ready
  );
endinterface

// File: rtl/uart_tx_frame.sv
// ---------------------------------------------------------------------------
// uart_tx_frame
// Parametrised UART transmit engine: start bit, DATA_BITS data bits (LSB
// first), optional even/odd parity bit, one or two stop bits. Each bit lasts
// 'baud' clk cycles, counted internally. Frames can be streamed with no idle
// gap: a new payload may be accepted in the last cycle of the final stop bit.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sel          block enable, gates acceptance of new frames only
//   baud         clk cycles per bit (latched on accept)
//   parity_mode  00 none, 01 even, 10 odd, 11 none (latched on accept)
//   stop2        1 = two stop bits, 0 = one (latched on accept)
//   up           payload handshake (din / din_valid / din_ready)
//   tx           serial line, idle high, registered
//   tx_busy      frame in progress, registered
//   done         one-cycle pulse in the last cycle of the final stop bit
//   cfg_err      baud below MIN_BAUD, combinational
// ---------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_W    = 20,
  parameter int MIN_BAUD  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sel,
  input  logic [BAUD_W-1:0] baud,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  uart_tx_frame_if.slave    up,
  output logic              tx,
  output logic              tx_busy,
  output logic              done,
  output logic              cfg_err
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [BAUD_W-1:0] CNT_ZERO   = {BAUD_W{1'b0}};
  localparam logic [BAUD_W-1:0] CNT_ONE    = BAUD_W'(1);
  localparam logic [BAUD_W-1:0] MIN_BAUD_V = BAUD_W'(MIN_BAUD);
  localparam logic [IDX_W-1:0]  IDX_ZERO   = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]  IDX_ONE    = IDX_W'(1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Parity bit for a payload: even = XOR of data, odd = inverted XOR.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data,
                                       input logic [1:0]           mode);
    calc_parity = (^data) ^ (mode == 2'b10);
  endfunction

  // Only 01 and 10 insert a parity bit; 00 and 11 both mean none.
  function automatic logic parity_on(input logic [1:0] mode);
    parity_on = (mode == 2'b01) || (mode == 2'b10);
  endfunction

  state_t               state_q,    state_d;
  logic [BAUD_W-1:0]    cnt_q,      cnt_d;
  logic [IDX_W-1:0]     idx_q,      idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] data_q,     data_d;
  logic                 par_q,      par_d;
  logic [BAUD_W-1:0]    baud_q,     baud_d;
  logic [1:0]           pmode_q,    pmode_d;
  logic                 stop2_q,    stop2_d;
  logic                 tx_q,       tx_d;
  logic                 busy_q,     busy_d;
  logic                 done_q,     done_d;

  logic                 last_stop_s;
  logic                 accept_s;

  // Configuration check, independent of state.
  assign cfg_err = (baud < MIN_BAUD_V);

  // Last cycle of the final stop bit: the only in-frame slot for a new accept.
  assign last_stop_s = (state_q == S_STOP) && (cnt_q == CNT_ZERO) &&
                       (stop_idx_q == stop2_q);

  // Ready is qualified by rst_n so it drops immediately during reset.
  assign up.din_ready = rst_n & sel & ~cfg_err &
                        ((state_q == S_IDLE) | last_stop_s);

  assign accept_s = up.din_valid & up.din_ready;

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign done    = done_q;

  // Next-state, counters, payload latch and next registered outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    // Accept only happens in IDLE or the last stop cycle, so the latch
    // never collides with the DATA-state shift below.
    data_d     = accept_s ? up.din : data_q;
    par_d      = accept_s ? calc_parity(up.din, parity_mode) : par_q;
    baud_d     = accept_s ? baud : baud_q;
    pmode_d    = accept_s ? parity_mode : pmode_q;
    stop2_d    = accept_s ? stop2 : stop2_q;

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d    = S_START;
          cnt_d      = baud - CNT_ONE;
          idx_d      = IDX_ZERO;
          stop_idx_d = 1'b0;
        end else begin
          state_d    = S_IDLE;
        end
      end

      S_START: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_DATA;
          cnt_d   = baud_q - CNT_ONE;
          idx_d   = IDX_ZERO;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_ZERO) begin
          cnt_d = baud_q - CNT_ONE;
          if (idx_q == IDX_LAST) begin
            idx_d      = IDX_ZERO;
            stop_idx_d = 1'b0;
            if (parity_on(pmode_q)) begin
              state_d = S_PARITY;
            end else begin
              state_d = S_STOP;
            end
          end else begin
            // Shift so the current data bit is always data_q[0].
            idx_d  = idx_q + IDX_ONE;
            data_d = data_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      S_PARITY: begin
        if (cnt_q == CNT_ZERO) begin
          state_d    = S_STOP;
          cnt_d      = baud_q - CNT_ONE;
          stop_idx_d = 1'b0;
        end else begin
          cnt_d      = cnt_q - CNT_ONE;
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_ZERO) begin
          if (stop_idx_q == stop2_q) begin
            stop_idx_d = 1'b0;
            if (accept_s) begin
              // Back-to-back: next start bit follows with no idle cycle.
              state_d = S_START;
              cnt_d   = baud - CNT_ONE;
              idx_d   = IDX_ZERO;
            end else begin
              state_d = S_IDLE;
              cnt_d   = CNT_ZERO;
            end
          end else begin
            stop_idx_d = 1'b1;
            cnt_d      = baud_q - CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: begin
        state_d    = S_IDLE;
        cnt_d      = CNT_ZERO;
        idx_d      = IDX_ZERO;
        stop_idx_d = 1'b0;
      end
    endcase

    // Outputs are computed from the next state so tx/tx_busy/done can be
    // registered without adding a cycle of latency.
    case (state_d)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_d[0];
      S_PARITY: tx_d = par_d;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_STOP) && (cnt_d == CNT_ZERO) &&
             (stop_idx_d == stop2_d);
  end

  // State, counters, latched frame settings and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= CNT_ZERO;
      idx_q      <= IDX_ZERO;
      stop_idx_q <= 1'b0;
      data_q     <= {DATA_BITS{1'b0}};
      par_q      <= 1'b0;
      baud_q     <= CNT_ZERO;
      pmode_q    <= 2'b00;
      stop2_q    <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      data_q     <= data_d;
      par_q      <= par_d;
      baud_q     <= baud_d;
      pmode_q    <= pmode_d;
      stop2_q    <= stop2_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_frame
// Directed bench for uart_tx_frame. Two instances share configuration:
// an 8-bit engine and a 5-bit engine. Expected line patterns are hand
// written, LSB = first bit on the line (start bit), one entry per bit period.
// Cycle 0 is the cycle of the accepting edge; sampling is 1 time unit after
// each rising edge.
// ---------------------------------------------------------------------------
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [19:0] baud;
  logic [1:0]  parity_mode;
  logic        stop2;

  logic tx8, busy8, done8, cerr8;
  logic tx5, busy5, done5, cerr5;

  uart_tx_frame_if #(.DATA_BITS(8)) if8 ();
  uart_tx_frame_if #(.DATA_BITS(5)) if5 ();

  uart_tx_frame #(.DATA_BITS(8), .BAUD_W(20), .MIN_BAUD(15)) dut8 (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .baud        (baud),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .up          (if8.slave),
    .tx          (tx8),
    .tx_busy     (busy8),
    .done        (done8),
    .cfg_err     (cerr8)
  );

  uart_tx_frame #(.DATA_BITS(5), .BAUD_W(20), .MIN_BAUD(15)) dut5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .baud        (baud),
    .parity_mode (parity_mode),
    .stop2       (stop2),
    .up          (if5.slave),
    .tx          (tx5),
    .tx_busy     (busy5),
    .done        (done5),
    .cfg_err     (cerr5)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic use5  = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a payload, confirm ready, pass the accepting edge; ends in cycle 1.
  task automatic start(input string name, input logic [8:0] d, input int bd,
                       input logic [1:0] pm, input logic s2, input logic five);
    logic r;
    use5        = five;
    baud        = 20'(bd);
    parity_mode = pm;
    stop2       = s2;
    if (five) begin
      if5.din       = d[4:0];
      if5.din_valid = 1'b1;
    end else begin
      if8.din       = d[7:0];
      if8.din_valid = 1'b1;
    end
    #1;
    r = five ? if5.din_ready : if8.din_ready;
    n_cmp++;
    if (r !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready_at_accept: got %b want 1", name, r);
    end
    tick();
    if8.din_valid = 1'b0;
    if5.din_valid = 1'b0;
  endtask

  // Walk cycles 1..nbits*bd checking tx/busy/done, then the first idle cycle.
  task automatic run_frame(input string name, input int nbits,
                           input logic [31:0] bits, input int bd,
                           input int flen, input int drop_at);
    int   e_tx = 0, e_busy = 0, e_done = 0, n_done = 0, first_bad = -1;
    int   total;
    logic t, b, d, r, rdy_end;
    total   = nbits * bd;
    rdy_end = 1'b0;
    for (int c = 1; c <= total; c++) begin
      t = use5 ? tx5   : tx8;
      b = use5 ? busy5 : busy8;
      d = use5 ? done5 : done8;
      r = use5 ? if5.din_ready : if8.din_ready;
      if (t !== bits[(c - 1) / bd]) begin
        e_tx++;
        if (first_bad < 0) first_bad = c;
      end
      if (b !== 1'b1) e_busy++;
      if (d === 1'b1) n_done++;
      if (d !== ((c % flen) == 0)) e_done++;
      if (c == flen) rdy_end = r;
      if (c == drop_at) begin
        if8.din_valid = 1'b0;
        if5.din_valid = 1'b0;
      end
      tick();
    end
    n_cmp++;
    if (e_tx != 0) begin
      n_bad++;
      $display("FAIL %s_tx: %0d wrong cycles, first at cycle %0d; want pattern %h at %0d cycles/bit",
               name, e_tx, first_bad, bits, bd);
    end
    n_cmp++;
    if (e_busy != 0) begin
      n_bad++;
      $display("FAIL %s_busy: low in %0d of %0d cycles, want always high", name, e_busy, total);
    end
    n_cmp++;
    if (e_done != 0 || n_done != total / flen) begin
      n_bad++;
      $display("FAIL %s_done: %0d pulses, %0d misplaced; want %0d at multiples of %0d",
               name, n_done, e_done, total / flen, flen);
    end
    n_cmp++;
    if (rdy_end !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ready_last_stop: got %b want 1", name, rdy_end);
    end
    t = use5 ? tx5   : tx8;
    b = use5 ? busy5 : busy8;
    n_cmp++;
    if (t !== 1'b1 || b !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_idle_after: tx=%b busy=%b want tx=1 busy=0", name, t, b);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    sel           = 1'b1;
    baud          = 20'd16;
    parity_mode   = 2'b00;
    stop2         = 1'b0;
    if8.din       = 8'h00;
    if8.din_valid = 1'b0;
    if5.din       = 5'h00;
    if5.din_valid = 1'b0;
    #12;
    n_cmp++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0 || if8.din_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b ready=%b want 1 0 0 0",
               tx8, busy8, done8, if8.din_ready);
    end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || if8.din_ready !== 1'b1 || tx5 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: tx8=%b busy8=%b ready8=%b tx5=%b want 1 0 1 1",
               tx8, busy8, if8.din_ready, tx5);
    end
  endtask

  task automatic test_8n1();
    start("8n1", 9'h0A5, 16, 2'b00, 1'b0, 1'b0);
    run_frame("8n1", 10, 32'h0000_034A, 16, 160, 0);
  endtask

  task automatic test_parity();
    start("8e1", 9'h0A5, 16, 2'b01, 1'b0, 1'b0);
    run_frame("8e1", 11, 32'h0000_054A, 16, 176, 0);
    start("8o1", 9'h0A5, 16, 2'b10, 1'b0, 1'b0);
    run_frame("8o1", 11, 32'h0000_074A, 16, 176, 0);
    start("8n2", 9'h0A5, 16, 2'b00, 1'b1, 1'b0);
    run_frame("8n2", 11, 32'h0000_074A, 16, 176, 0);
  endtask

  task automatic test_back_to_back();
    logic r;
    use5          = 1'b0;
    baud          = 20'd16;
    parity_mode   = 2'b00;
    stop2         = 1'b0;
    if8.din       = 8'h3C;
    if8.din_valid = 1'b1;
    #1;
    r = if8.din_ready;
    n_cmp++;
    if (r !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_first_ready: got %b want 1", r);
    end
    tick();
    if8.din = 8'hC3;
    // Frame 1 = 0x278, frame 2 = 0x386 directly behind it.
    run_frame("b2b", 20, 32'h000E_1A78, 16, 160, 161);
  endtask

  task automatic test_cfg_err();
    baud          = 20'd14;
    if8.din       = 8'h55;
    if8.din_valid = 1'b1;
    #1;
    n_cmp++;
    if (cerr8 !== 1'b1 || if8.din_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_err_14: cfg_err=%b ready=%b want 1 0", cerr8, if8.din_ready);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_err_blocked: tx=%b busy=%b want 1 0", tx8, busy8);
    end
    if8.din_valid = 1'b0;
    baud          = 20'd15;
    #1;
    n_cmp++;
    if (cerr8 !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_err_15: cfg_err=%b want 0", cerr8);
    end
    start("b15", 9'h0A5, 15, 2'b00, 1'b0, 1'b0);
    run_frame("b15", 10, 32'h0000_034A, 15, 150, 0);
    sel           = 1'b0;
    if8.din_valid = 1'b1;
    #1;
    n_cmp++;
    if (if8.din_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL sel_off_ready: got %b want 0", if8.din_ready);
    end
    tick();
    tick();
    n_cmp++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0) begin
      n_bad++;
      $display("FAIL sel_off_blocked: tx=%b busy=%b want 1 0", tx8, busy8);
    end
    if8.din_valid = 1'b0;
    sel           = 1'b1;
  endtask

  task automatic test_reset_mid();
    start("rst", 9'h0A5, 16, 2'b00, 1'b0, 1'b0);
    // Advance from cycle 1 to cycle 70: data bit 3 of 0xA5, which is 0.
    for (int i = 0; i < 69; i++) tick();
    n_cmp++;
    if (tx8 !== 1'b0 || busy8 !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_pre: tx=%b busy=%b want 0 1", tx8, busy8);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx8 !== 1'b1 || busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async: tx=%b busy=%b done=%b want 1 0 0", tx8, busy8, done8);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    start("post_rst", 9'h03C, 16, 2'b00, 1'b0, 1'b0);
    run_frame("post_rst", 10, 32'h0000_0278, 16, 160, 0);
  endtask

  task automatic test_five_bits();
    start("5o1", 9'h01F, 15, 2'b10, 1'b0, 1'b1);
    run_frame("5o1", 8, 32'h0000_00BE, 15, 120, 0);
    use5 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_cfg_err();
    test_reset_mid();
    test_five_bits();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmit engine that replaces the fixed 8N1 transmit control path. It counts baud periods internally from a divisor and supports a configurable data width, optional even/odd parity and one or two stop bits. Bytes arrive over a valid/ready handshake, so a host FIFO or bus bridge can stream frames back-to-back. It sits between the UART register/FIFO logic and the tx pad.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9.
BAUD_W, 20, width of baud divisor input.
MIN_BAUD, 15, smallest legal divisor in clk cycles per bit.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
sel  in  1  block enable; gates acceptance of new frames only.
baud  in  BAUD_W  clk cycles per bit.
parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none.
stop2  in  1  1 = two stop bits, 0 = one.
din  in  DATA_BITS  frame payload, LSB sent first.
din_valid  in  1  payload valid.
din_ready  out  1  block can accept payload this cycle.
tx  out  1  serial line, idle high.
tx_busy  out  1  frame in progress.
done  out  1  one-cycle pulse on the last cycle of the final stop bit.
cfg_err  out  1  baud < MIN_BAUD (combinational).

Behaviour:
- Reset (async, rst_n=0) sets:
  - tx=1, tx_busy=0, done=0, din_ready=0.
  - State IDLE; all counters 0.
  - Reset mid-frame forces tx high immediately; the frame is discarded.
- cfg_err = (baud < MIN_BAUD). It is combinational and independent of state.
- din_ready=1 when rst_n=1 and sel=1 and cfg_err=0 and either:
  - state=IDLE, or
  - state=STOP in the last cycle of the final stop bit (back-to-back case).
- Accept happens on a rising clk edge with din_valid & din_ready. On accept, latch din, baud, parity_mode and stop2. Input changes during a frame have no effect.
- State machine and tx levels:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=data[bit_idx], bit_idx 0..DATA_BITS-1.
  - PARITY: tx=parity bit. Skipped when the mode is none.
  - STOP: tx=1, for 1 or 2 bit periods.
- Transitions:
  - IDLE->START on accept.
  - START->DATA.
  - DATA->PARITY or STOP after bit DATA_BITS-1.
  - PARITY->STOP.
  - STOP->IDLE, or STOP->START if an accept occurs in the final cycle.
- Timing:
  - Every bit is held exactly baud_latched clk cycles. A down-counter loads baud_latched-1 at each bit start and advances the state at 0.
  - First start-bit cycle is the cycle after accept.
  - Frame length in cycles = baud × (1 + DATA_BITS + P + S), where P = 0/1 for parity and S = 1/2 for stop bits.
- Parity:
  - Even: XOR of latched data.
  - Odd: inverted XOR of latched data.
  - Computed once, from the latched data.
- tx_busy=1 from the cycle after accept through the last stop cycle. In the back-to-back case it stays high continuously.
- done asserts in the final cycle of the last stop bit, coincident with the back-to-back din_ready.
- sel deassertion mid-frame does not abort; the frame completes and no new accept occurs.
- cfg_err going high mid-frame does not abort (baud is already latched). It blocks the next accept.
- tx is a registered output (no glitches).
- Counter widths: baud counter BAUD_W bits; bit index clog2(DATA_BITS) bits; stop counter 1 bit.

Test Plan:
- Basic 8N1 frame. Stimulus: baud=16, 8N1, din=0xA5 accepted at cycle 0. Required:
  - tx low for cycles 1-16.
  - Then data bits 1,0,1,0,0,1,0,1, 16 cycles each.
  - Stop bit high for cycles 145-160.
  - done pulse at cycle 160; tx_busy cycles 1-160.
- Parity. Stimulus: baud=16, din=0xA5. Required:
  - Even parity sends parity bit 0 (cycles 145-160), stop bit cycles 161-176.
  - Odd parity sends parity bit 1.
  - stop2=1 with parity none: done at cycle 176.
- Back-to-back. Stimulus: din_valid held high with 0x3C then 0xC3. Required:
  - Second accept in cycle 160.
  - Second start bit begins cycle 161; no idle-high gap.
  - tx_busy never drops.
  - Exactly two done pulses.
- Configuration errors and enable. Stimulus: baud=14. Required:
  - cfg_err=1, din_ready=0, tx stays 1 despite din_valid.
  - baud=15 → cfg_err=0 and accept succeeds.
  - sel=0 → din_ready=0.
- Reset mid-frame. Stimulus: rst_n low during DATA bit 3. Required:
  - tx=1 and tx_busy=0 asynchronously, before the next clk edge.
  - After release, the next accept produces a full clean frame.
- DATA_BITS=5. Stimulus: din=0x1F with odd parity, baud=15. Required:
  - Five 1s, parity bit 0.
  - Frame is 8 bits × 15 = 120 cycles; done at cycle 120.
